tmem_bus_arb_driver: RTL

TMEM_BUS_ARB_DRIVER -- requirements
Module: tmem_bus_arb_driver

---
 rtl/tmem_bus_pkg.sv | 25 ++
 rtl/tmem_rr_arb.sv | 42 ++++
 rtl/tmem_bus_arb_driver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tmem_bus_pkg.sv
// rtl/tmem_bus_pkg.sv - shared constants and helpers for the TMEM bus arbiter/driver
//
// Holds the FSM state encoding, the default parameter values used by the
// top module and the arbiter, and the per-byte even-parity helper.

package tmem_bus_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // Default parameter values
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_TURN_CYC  = 1;
    localparam int DEF_MAX_BURST = 8;

    // Even parity bit for one byte: set when the byte holds an odd number of ones,
    // so that byte plus parity bit always carries an even count.
    function automatic logic byte_even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tmem_rr_arb.sv
// rtl/tmem_rr_arb.sv - round-robin arbiter producing a one-hot winner
//
// Ports:
//   i_req    [NUM_CH]  request vector
//   i_ptr    [PTR_W]   last granted channel; search starts at i_ptr+1 and wraps
//   o_winner [NUM_CH]  one-hot winner, all-zero when no request

module tmem_rr_arb
    import tmem_bus_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_winner
);

    // One extra bit so ptr+offset never overflows before the modulo wrap.
    localparam logic [PTR_W:0] NCH = (PTR_W+1)'(NUM_CH);

    logic [PTR_W:0] w_pos;
    logic           w_found;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_pos    = '0;
        // Offset NUM_CH visits the pointer channel itself last.
        for (int k = 1; k <= NUM_CH; k++) begin
            w_pos = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_pos >= NCH) begin
                w_pos = w_pos - NCH;
            end
            if (!w_found && i_req[w_pos[PTR_W-1:0]]) begin
                o_winner[w_pos[PTR_W-1:0]] = 1'b1;
                w_found                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmem_bus_arb_driver.sv
// rtl/tmem_bus_arb_driver.sv - round-robin arbiter and tristate driver for the shared TMEM data bus
//
// Optional feature macro: TMEM_DRV_PARITY_EN adds the tmem_par output.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_l    asynchronous active-low reset
//   req        [NUM_CH]         per-channel level-held bus request
//   wdata      [NUM_CH*DATA_W]  per-channel write data, channel i at [i*DATA_W +: DATA_W]
//   grant      [NUM_CH]         registered one-hot grant; granted data is sampled this cycle
//   tmem_data  [DATA_W]         shared bus, driven only while tmem_oe=1
//   tmem_oe                     registered output enable (previous-cycle grant)
//   busy                        high whenever the FSM is not IDLE
//   tmem_par   [DATA_W/8]       per-byte even parity of tmem_data, tristated with tmem_oe
//                               (only with TMEM_DRV_PARITY_EN)

module tmem_bus_arb_driver
    import tmem_bus_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int TURN_CYC  = DEF_TURN_CYC,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        grant,
    inout  wire  [DATA_W-1:0]        tmem_data,
    output logic                     tmem_oe,
    output logic                     busy
`ifdef TMEM_DRV_PARITY_EN
    ,
    output wire  [DATA_W/8-1:0]      tmem_par
`endif
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Burst counter holds the number of beats already completed in the current
    // grant, so the beat being granted now is the last allowed one at MAX_BURST-1.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] BURST_SAT  = 8'(MAX_BURST);
    localparam logic [1:0] TURN_LOAD  = (TURN_CYC > 0) ? 2'(TURN_CYC - 1) : 2'd0;

    logic [1:0]        r_state;
    logic [NUM_CH-1:0] r_grant;
    logic [PTR_W-1:0]  r_ptr;
    logic [7:0]        r_cnt;
    logic [1:0]        r_turn;
    logic              r_oe;
    logic [DATA_W-1:0] r_data;

    logic [1:0]        w_nstate;
    logic [NUM_CH-1:0] w_ngrant;
    logic [PTR_W-1:0]  w_nptr;
    logic [7:0]        w_ncnt;
    logic [1:0]        w_nturn;
    logic              w_load;

    logic [NUM_CH-1:0] w_arb_req;
    logic [NUM_CH-1:0] w_winner;
    logic [PTR_W-1:0]  w_win_idx;
    logic              w_others;
    logic              w_limit;
    logic              w_keep;
    logic [DATA_W-1:0] w_mux;

    // While driving, the current owner is masked so a burst-limit release
    // always hands over to a different channel.
    assign w_arb_req = (r_state == ST_DRIVE) ? (req & ~r_grant) : req;
    assign w_others  = |(req & ~r_grant);
    assign w_limit   = (r_cnt >= BURST_LAST);
    assign w_keep    = (|(req & r_grant)) && !(w_limit && w_others);

    tmem_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req    (w_arb_req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_grant[i]) begin
                w_mux = w_mux | wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ngrant = r_grant;
        w_nptr   = r_ptr;
        w_ncnt   = r_cnt;
        w_nturn  = r_turn;
        w_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_keep) begin
                    if (r_cnt != BURST_SAT) begin
                        w_ncnt = r_cnt + 8'd1;
                    end
                end else if (!w_others) begin
                    w_nstate = ST_IDLE;
                    w_ngrant = '0;
                end else if (TURN_CYC > 0) begin
                    w_nstate = ST_TURN;
                    w_ngrant = '0;
                    w_nturn  = TURN_LOAD;
                end else begin
                    w_load = 1'b1;
                end
            end
            ST_TURN: begin
                if (r_turn == 2'd0) begin
                    if (|req) begin
                        w_load = 1'b1;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end else begin
                    w_nturn = r_turn - 2'd1;
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_ngrant = '0;
            end
        endcase
        if (w_load) begin
            w_nstate = ST_DRIVE;
            w_ngrant = w_winner;
            w_nptr   = w_win_idx;
            w_ncnt   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= PTR_W'(NUM_CH - 1);
            r_cnt   <= 8'd0;
            r_turn  <= 2'd0;
            r_oe    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_nstate;
            r_grant <= w_ngrant;
            r_ptr   <= w_nptr;
            r_cnt   <= w_ncnt;
            r_turn  <= w_nturn;
            r_oe    <= |r_grant;
            if (|r_grant) begin
                r_data <= w_mux;
            end
        end
    end

    assign grant     = r_grant;
    assign tmem_oe   = r_oe;
    assign busy      = (r_state != ST_IDLE);
    assign tmem_data = r_oe ? r_data : {DATA_W{1'bz}};

`ifdef TMEM_DRV_PARITY_EN
    logic [DATA_W/8-1:0] w_par;

    always_comb begin
        w_par = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            w_par[b] = byte_even_par(r_data[b*8 +: 8]);
        end
    end

    assign tmem_par = r_oe ? w_par : {(DATA_W/8){1'bz}};
`endif

endmodule
